pwm_core: RTL and testbench
===========================

# pwm_core

PWM generation stage directly downstream of the register interface. Consumes the 32-bit `ctrl` word produced by the register block and drives the PWM pin. Returns a live 32-bit status word to the register block's `status_in` input. Contains a prescaler, a period counter, shadow registers and a two-state enable FSM.

## Interface

Parameters:
- `PRESC_W`, default 4: width of the prescaler field, `ctrl[4+PRESC_W-1:4]`. Legal range 1..4.

Ports:
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-high reset.
- `ctrl` in 32: control word from the register block.
  - `[0]` en.
  - `[1]` pol (1 = inverted output).
  - `[7:4]` presc.
  - `[23:16]` duty.
  - `[31:24]` period.
  - All other bits are ignored.
- `pwm_out` out 1: registered PWM output.
- `status_out` out 32: connects to the register block's `status_in`.
  - `[7:0]` cnt.
  - `[15:8]` duty_s.
  - `[23:16]` period_s.
  - `[24]` running.
  - `[25]` pwm_out.
  - `[31:26]` period count (wraps).

## Operation

- FSM states: IDLE, RUN.
  - IDLE→RUN: on the first edge with `en`=1. On that edge, load `duty_s` and `period_s` from `ctrl`, and clear the prescaler counter, `cnt` and the period count.
  - RUN→IDLE: on the first edge with `en`=0. On that edge, clear `cnt` and the prescaler counter. `duty_s` and `period_s` hold their values.
- Prescaler: `tick`=1 for one clk every (presc+1) clk cycles while in RUN. presc=0 gives a tick every cycle. presc is sampled live.
- Counter: increments on `tick`.
  - At `cnt`==`period_s` with `tick`: `cnt`→0, the period count increments modulo 64, and a period boundary occurs.
  - `period_s`=0: `cnt` stays 0 and every tick is a period boundary.
- Raw compare: raw = (`cnt` < `duty_s`).
  - `duty_s`=0: always low.
  - `duty_s` > `period_s`: always high (100%).
  - Compare is unsigned 8-bit; no overflow path.
- Output: `pwm_out` <= (state==RUN) ? raw^pol : pol. The idle level equals the inactive level. pol is sampled live.
- Shadow update (see Configuration): `duty_s` and `period_s` take new `ctrl` values only at a period boundary.
- Simultaneous events:
  - `en` falling on a period-boundary edge: the disable wins. State→IDLE and the period count still increments.
  - `en` and a new duty written in the same cycle as enable: the new values are loaded directly.

## Timing

- Reset values: state IDLE, `cnt`=0, prescaler=0, `duty_s`=0, `period_s`=0, period count=0, `pwm_out`=0, `status_out`=0.
- Reset asserted mid-operation: all of the above are applied immediately, asynchronously.
- `pwm_out` and `status_out` are registered. `pwm_out` reflects the `cnt` value from the previous edge (1-cycle lag).
- `en` sampled high at edge N:
  - running=1 after edge N.
  - First active `pwm_out` level after edge N+1.
- `en` sampled low at edge M: `pwm_out`=pol after edge M+1.
- Period length in clk cycles = (period_s+1)·(presc+1).
- High time in clk cycles = min(duty_s, period_s+1)·(presc+1).

## Configuration

- `PWM_SHADOW_EN` defined: `duty`/`period` written during RUN take effect at the next period boundary. The glitch-free boundary rule in Operation applies.
- `PWM_SHADOW_EN` undefined:
  - `duty_s`/`period_s` follow `ctrl` every clk.
  - If the new period is below the current `cnt`, `cnt` wraps to 0 on the next tick and that tick counts as a period boundary.
  - `status_out[15:8]` and `[23:16]` mirror `ctrl` with 1-cycle lag.

## Test plan

- Reset, then `ctrl`=0x0A040001 (period 10, duty 4, presc 0, en=1) → `pwm_out` high 4 / low 7 clk, repeating every 11 clk. `status_out[24]`=1.
- presc=3, period=4, duty=2 → high 8 clk per 20-clk period. `status_out[31:26]` increments once per 20 clk.
- Edge duty values:
  - duty=0 → `pwm_out` constantly 0.
  - duty=0xFF, period=0x10 → `pwm_out` constantly 1.
  - pol=1 → both of the above are inverted.
- `PWM_SHADOW_EN`: change duty 4→8 when `cnt`=2 → the current period still has 4 high cycles; the next period has 8. Without the macro, the current period extends its high time to `cnt`=7.
- Clear `en` mid-period → `pwm_out`=pol one cycle after the sampling edge. `cnt`=0, `status_out[24]`=0.
- Assert `reset_n` mid-RUN → all outputs 0 immediately. After release with `en` still 1, RUN restarts from `cnt`=0.

Source files
------------

// File: rtl/pwm_core.sv
// pwm_core: PWM generation stage fed by the register block's ctrl word.
// It has a prescaler, a period counter, duty/period shadow registers and a
// two-state IDLE/RUN enable FSM, and it returns a live status word.
// Optional feature macro: PWM_SHADOW_EN.
//   defined   - duty/period written while running take effect at the next
//               period boundary (glitch-free update).
//   undefined - duty/period follow ctrl every clock.
// Reset: reset_n is asynchronous and asserted HIGH (legacy naming kept).
module pwm_core #(
  parameter int PRESC_W = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ctrl,
  output logic        pwm_out,
  output logic [31:0] status_out
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Decoded control fields, all sampled live
  logic               en_s;
  logic               pol_s;
  logic [PRESC_W-1:0] presc_s;
  logic [7:0]         duty_in_s;
  logic [7:0]         period_in_s;
  logic               unused_ctrl_s;

  assign en_s          = ctrl[0];
  assign pol_s         = ctrl[1];
  assign presc_s       = ctrl[4+PRESC_W-1:4];
  assign duty_in_s     = ctrl[23:16];
  assign period_in_s   = ctrl[31:24];
  assign unused_ctrl_s = ^{ctrl[15:8], ctrl[3:2]};

  // State and datapath registers
  state_t             state_q,     state_d;
  logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [7:0]         cnt_q,       cnt_d;
  logic [7:0]         duty_s_q,    duty_s_d;
  logic [7:0]         period_s_q,  period_s_d;
  logic [5:0]         pcount_q,    pcount_d;
  logic               pwm_q,       pwm_d;
  logic [31:0]        status_q,    status_d;

  // Per-cycle events
  logic tick_s;
  logic boundary_s;
  logic raw_s;

  // Prescaler tick, period boundary and raw duty compare
  always_comb begin
    tick_s     = 1'b0;
    boundary_s = 1'b0;
    raw_s      = 1'b0;
    if (state_q == RUN) begin
      // '>=' keeps the prescaler safe when presc is lowered on the fly
      tick_s = (presc_cnt_q >= presc_s);
    end else begin
      tick_s = 1'b0;
    end
    // '>=' also covers period_s==0 and a period lowered below cnt
    boundary_s = tick_s && (cnt_q >= period_s_q);
    raw_s      = (cnt_q < duty_s_q);
  end

  // FSM next state, counters and shadow registers
  always_comb begin
    state_d     = state_q;
    presc_cnt_d = presc_cnt_q;
    cnt_d       = cnt_q;
    duty_s_d    = duty_s_q;
    period_s_d  = period_s_q;
    pcount_d    = pcount_q;

    case (state_q)
      IDLE: begin
        if (en_s) begin
          state_d     = RUN;
          presc_cnt_d = {PRESC_W{1'b0}};
          cnt_d       = 8'd0;
          pcount_d    = 6'd0;
          duty_s_d    = duty_in_s;
          period_s_d  = period_in_s;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // The period count advances on a boundary even if disable wins
        if (boundary_s) begin
          pcount_d = pcount_q + 6'd1;
        end else begin
          pcount_d = pcount_q;
        end
        if (!en_s) begin
          state_d     = IDLE;
          cnt_d       = 8'd0;
          presc_cnt_d = {PRESC_W{1'b0}};
        end else begin
          if (tick_s) begin
            presc_cnt_d = {PRESC_W{1'b0}};
          end else begin
            presc_cnt_d = presc_cnt_q + PRESC_W'(1);
          end
          if (boundary_s) begin
            cnt_d = 8'd0;
`ifdef PWM_SHADOW_EN
            duty_s_d   = duty_in_s;
            period_s_d = period_in_s;
`endif
          end else if (tick_s) begin
            cnt_d = cnt_q + 8'd1;
          end else begin
            cnt_d = cnt_q;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        presc_cnt_d = {PRESC_W{1'b0}};
        cnt_d       = 8'd0;
      end
    endcase

`ifndef PWM_SHADOW_EN
    // Without shadowing the compare values track ctrl every clock
    duty_s_d   = duty_in_s;
    period_s_d = period_in_s;
`endif
  end

  // Output level and status word, registered from next-state values
  always_comb begin
    pwm_d    = pol_s;
    status_d = 32'd0;
    if (state_q == RUN) begin
      pwm_d = raw_s ^ pol_s;
    end else begin
      pwm_d = pol_s;
    end
    status_d = {pcount_d, pwm_d, (state_d == RUN), period_s_d, duty_s_d, cnt_d};
  end

  // All state, with asynchronous high-active reset
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q     <= IDLE;
      presc_cnt_q <= {PRESC_W{1'b0}};
      cnt_q       <= 8'd0;
      duty_s_q    <= 8'd0;
      period_s_q  <= 8'd0;
      pcount_q    <= 6'd0;
      pwm_q       <= 1'b0;
      status_q    <= 32'd0;
    end else begin
      state_q     <= state_d;
      presc_cnt_q <= presc_cnt_d;
      cnt_q       <= cnt_d;
      duty_s_q    <= duty_s_d;
      period_s_q  <= period_s_d;
      pcount_q    <= pcount_d;
      pwm_q       <= pwm_d;
      status_q    <= status_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign status_out = status_q;

endmodule

// File: tb/tb_pwm_core.sv
// Directed testbench for pwm_core. Inputs change 1 time unit after a rising
// edge, and outputs are sampled at that same point.
module tb_pwm_core;

  logic        clk;
  logic        reset_n;
  logic [31:0] ctrl;
  logic        pwm_out;
  logic [31:0] status_out;

  int checks_n;
  int errors_n;

  pwm_core #(.PRESC_W(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ctrl       (ctrl),
    .pwm_out    (pwm_out),
    .status_out (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check, reports a mismatch
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_n = checks_n + 1;
    if (obs !== exp) begin
      errors_n = errors_n + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_count(input int n, output int highs);
    highs = 0;
    for (int k = 0; k < n; k++) begin
      step();
      if (pwm_out === 1'b1) highs = highs + 1;
    end
  endtask

  task automatic disable_run();
    ctrl = 32'h0000_0000;
    step();
    step();
  endtask

  int h1;
  int h2;
  int exp_h1;

  initial begin
    checks_n = 0;
    errors_n = 0;
    reset_n  = 1'b1;
    ctrl     = 32'h0000_0000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_pwm", {31'd0, pwm_out}, 32'd0);
    check("rst_status", status_out, 32'd0);
    reset_n = 1'b0;
    step();
    check("idle_status", status_out, 32'd0);

    // Period 10, duty 4, presc 0: high 4 / low 7 every 11 clocks
    ctrl = 32'h0A04_0001;
    step();
    check("t1_running", {31'd0, status_out[24]}, 32'd1);
    check("t1_idle_lvl", {31'd0, pwm_out}, 32'd0);
    check("t1_duty_s", {24'd0, status_out[15:8]}, 32'd4);
    check("t1_period_s", {24'd0, status_out[23:16]}, 32'd10);
    check("t1_cnt0", {24'd0, status_out[7:0]}, 32'd0);
    for (int i = 0; i < 22; i++) begin
      step();
      check("t1_pwm", {31'd0, pwm_out}, ((i % 11) < 4) ? 32'd1 : 32'd0);
      check("t1_cnt", {24'd0, status_out[7:0]}, 32'((i + 1) % 11));
    end
    check("t1_pcount", {26'd0, status_out[31:26]}, 32'd2);
    disable_run();

    // presc 3, period 4, duty 2: 8 high per 20-clock period
    ctrl = 32'h0402_0031;
    step();
    run_count(20, h1);
    check("t2_high_a", 32'(h1), 32'd8);
    check("t2_pcount_a", {26'd0, status_out[31:26]}, 32'd1);
    run_count(20, h1);
    check("t2_high_b", 32'(h1), 32'd8);
    check("t2_pcount_b", {26'd0, status_out[31:26]}, 32'd2);
    disable_run();

    // duty 0 -> always low
    ctrl = 32'h0A00_0001;
    step();
    run_count(22, h1);
    check("duty0_high", 32'(h1), 32'd0);
    disable_run();

    // duty 0xFF > period 0x10 -> always high
    ctrl = 32'h10FF_0001;
    step();
    run_count(22, h1);
    check("dutyff_high", 32'(h1), 32'd22);
    disable_run();

    // pol=1, duty 0 -> always high
    ctrl = 32'h0A00_0003;
    step();
    check("pol_idle_lvl", {31'd0, pwm_out}, 32'd1);
    run_count(22, h1);
    check("pol_duty0_high", 32'(h1), 32'd22);
    disable_run();

    // pol=1, duty 0xFF -> always low
    ctrl = 32'h10FF_0003;
    step();
    run_count(22, h1);
    check("pol_dutyff_high", 32'(h1), 32'd0);
    disable_run();

    // period 0: cnt stays 0, every tick is a boundary; disable on a boundary
    ctrl = 32'h0001_0001;
    step();
    run_count(5, h1);
    check("p0_high", 32'(h1), 32'd5);
    check("p0_cnt", {24'd0, status_out[7:0]}, 32'd0);
    check("p0_pcount", {26'd0, status_out[31:26]}, 32'd5);
    ctrl = 32'h0001_0000;
    step();
    check("p0_dis_running", {31'd0, status_out[24]}, 32'd0);
    check("p0_dis_pcount", {26'd0, status_out[31:26]}, 32'd6);
    step();
    check("p0_dis_pwm", {31'd0, pwm_out}, 32'd0);
    disable_run();

    // Clear en mid-period with pol=1
    ctrl = 32'h0A04_0003;
    step();
    step();
    step();
    check("dis_pre_pwm", {31'd0, pwm_out}, 32'd0);
    ctrl = 32'h0A04_0002;
    step();
    check("dis_running", {31'd0, status_out[24]}, 32'd0);
    check("dis_cnt", {24'd0, status_out[7:0]}, 32'd0);
    check("dis_lag_pwm", {31'd0, pwm_out}, 32'd0);
    step();
    check("dis_pol_pwm", {31'd0, pwm_out}, 32'd1);
    disable_run();

    // Duty 4 -> 8 while cnt==2
`ifdef PWM_SHADOW_EN
    exp_h1 = 4;
`else
    exp_h1 = 8;
`endif
    ctrl = 32'h0A04_0001;
    step();
    h1 = 0;
    h2 = 0;
    for (int i = 0; i < 22; i++) begin
      step();
      if (pwm_out === 1'b1) begin
        if (i < 11) h1 = h1 + 1;
        else        h2 = h2 + 1;
      end
      if (i == 1) ctrl = 32'h0A08_0001;
      if (i == 2) check("sh_duty_s", {24'd0, status_out[15:8]}, 32'(exp_h1));
    end
    check("sh_high_cur", 32'(h1), 32'(exp_h1));
    check("sh_high_next", 32'(h2), 32'd8);
    disable_run();

    // Reset mid-RUN, then restart with en still high
    ctrl = 32'h0A04_0001;
    step();
    step();
    step();
    check("rr_pre_pwm", {31'd0, pwm_out}, 32'd1);
    #2;
    reset_n = 1'b1;
    #1;
    check("rr_async_pwm", {31'd0, pwm_out}, 32'd0);
    check("rr_async_status", status_out, 32'd0);
    step();
    check("rr_held_status", status_out, 32'd0);
    reset_n = 1'b0;
    step();
    check("rr_running", {31'd0, status_out[24]}, 32'd1);
    check("rr_cnt0", {24'd0, status_out[7:0]}, 32'd0);
    step();
    check("rr_pwm", {31'd0, pwm_out}, 32'd1);
    check("rr_cnt1", {24'd0, status_out[7:0]}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks_n, errors_n);
    $finish;
  end

endmodule
